tribus_reader: RTL and testbench

- Receiving end of the shared 8-bit tristate bus built from tristate_1x_8 drivers.
- Generates the complementary enable pairs (en/en_b) for up to N_SRC drivers, one source at a time, with a dead turnaround cycle between sources.
- Samples the resolved bus, buffers words in a small FIFO and presents them on a valid/ready stream.
- Sits between bus-side sources (register file / datapath outputs) and the downstream consumer.

---
 rtl/tribus_pkg.sv | 53 +++++
 rtl/tribus_fifo.sv | 72 +++++++
 rtl/tribus_reader.sv | 129 ++++++++++++
 tb/tb_tribus_reader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tribus_pkg
//  Description : Shared types and helpers for the tristate-bus reader.
//                Holds the FSM state encoding, the default sizing constants
//                and the round-robin pick used by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package tribus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam int c_WIDTH_DEFAULT = 8;
    localparam int c_N_SRC_DEFAULT = 4;
    localparam int c_DEPTH_DEFAULT = 4;

    // Round-robin find-first: the first set bit of req at or after ptr,
    // wrapping at n_src. Sized for the largest supported bus (8 sources).
    // The caller only uses the result when at least one req bit is set.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n_src
    );
        logic [2:0] pick;
        logic       found;
        logic [3:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n_src) begin
                // ptr < n_src and i < n_src, so one subtraction wraps it
                idx = {1'b0, ptr} + 4'(i);
                if (idx >= 4'(n_src)) begin
                    idx = idx - 4'(n_src);
                end
                if (!found && (idx < 4'd8) && req[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tribus_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tribus_fifo
//  Description : Small synchronous FIFO holding captured bus words.
//                Head word is shown combinationally on o_data.
//  Ports       : clk, rst (async active-high), i_push/i_data write side,
//                i_pop read side, o_data head word, o_count fill level,
//                o_empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module tribus_fifo
    import tribus_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Pop on empty is ignored; push on full is dropped defensively.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (r_count != c_CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Cleared so the head word reads as zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tribus_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tribus_reader
//  Description : Receiving end of a shared tristate bus. Grants one source
//                at a time (round-robin), drives its en/en_b pair for a
//                settle cycle plus a sample cycle, inserts a dead turnaround
//                cycle, and queues captured words on a valid/ready stream.
//  Ports       : clk, reset (async active-high)
//                req[N_SRC]      per-source word-ready
//                en/en_b[N_SRC]  complementary driver enables
//                ack[N_SRC]      one-cycle capture pulse
//                bus_in[WIDTH]   resolved bus
//                out_data/out_src/out_valid/out_ready  output stream
//                busy            FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module tribus_reader
    import tribus_pkg::*;
#(
    parameter int N_SRC = c_N_SRC_DEFAULT,
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         req,
    output logic [N_SRC-1:0]         en,
    output logic [N_SRC-1:0]         en_b,
    output logic [N_SRC-1:0]         ack,
    input  logic [WIDTH-1:0]         bus_in,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_SRC)-1:0] out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int c_SW = $clog2(N_SRC);
    localparam int c_CW = $clog2(DEPTH) + 1;

    state_t           r_state;
    logic [c_SW-1:0]  r_grant;
    logic [c_SW-1:0]  r_rr_ptr;
    logic [N_SRC-1:0] r_en;
    logic [N_SRC-1:0] r_ack;

    logic [c_SW-1:0]       w_pick;
    logic [c_SW-1:0]       w_next_ptr;
    logic                  w_room;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [c_CW-1:0]       w_count;
    logic [c_SW+WIDTH-1:0] w_head;

    assign w_pick     = c_SW'(rr_pick(8'(req), 3'(r_rr_ptr), N_SRC));
    assign w_next_ptr = (r_grant == c_SW'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
    assign w_room     = (w_count < c_CW'(DEPTH));
    assign w_push     = (r_state == SAMPLE);
    assign w_pop      = out_valid && out_ready;

    // en comes straight from a flop, so en_b tracks it bit for bit and the
    // asynchronous reset releases the bus without waiting for an edge.
    assign en        = r_en;
    assign en_b      = ~r_en;
    assign ack       = r_ack;
    assign busy      = (r_state != IDLE);
    assign out_valid = !w_empty;
    assign out_data  = w_head[WIDTH-1:0];
    assign out_src   = w_head[WIDTH +: c_SW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_en     <= '0;
            r_ack    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    // Only grant when the word is guaranteed a FIFO slot.
                    if ((|req) && w_room) begin
                        r_grant <= w_pick;
                        r_en    <= N_SRC'(1) << w_pick;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Settle cycle; ack lands in the sample cycle.
                    r_ack   <= r_en;
                    r_state <= SAMPLE;
                end
                SAMPLE: begin
                    r_ack    <= '0;
                    r_en     <= '0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= TURN;
                end
                TURN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_en    <= '0;
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    tribus_fifo #(
        .WIDTH (c_SW + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  ({r_grant, bus_in}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_tribus_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tribus_reader
//  Description : Directed self-checking bench for tribus_reader. Models four
//                bus drivers on one shared bus and checks timing, arbitration
//                order, backpressure, push/pop overlap and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tribus_reader;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic [N-1:0] req       = '0;
    logic         out_ready = 1'b0;
    logic [N-1:0] en;
    logic [N-1:0] en_b;
    logic [N-1:0] ack;
    logic [W-1:0] bus_in;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_valid;
    logic         busy;

    logic [W-1:0] src_data [N];
    int           n_drv;
    int           vectors     = 0;
    int           miscompares = 0;

    tribus_reader #(.N_SRC(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .en        (en),
        .en_b      (en_b),
        .ack       (ack),
        .bus_in    (bus_in),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared bus: one enabled driver puts its word on the bus; no driver or
    // several drivers leave the bus undefined. n_drv exposes contention.
    always_comb begin
        n_drv  = 0;
        bus_in = 'x;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                n_drv  = n_drv + 1;
                bus_in = src_data[i];
            end
        end
        if (n_drv > 1) bus_in = 'x;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; out_ready = 1'b0;
        tick(); tick();
        vectors++; if (en !== 4'b0000) begin miscompares++; $display("FAIL reset_en got %b want 0000", en); end
        vectors++; if (en_b !== 4'b1111) begin miscompares++; $display("FAIL reset_en_b got %b want 1111", en_b); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got %b want 0000", ack); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", out_data); end
        vectors++; if (out_src !== 2'd0) begin miscompares++; $display("FAIL reset_src got %0d want 0", out_src); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_source();
        src_data[1] = 8'hA5;
        req = 4'b0010;
        tick(); // cycle 1: DRIVE
        vectors++; if (en !== 4'b0010) begin miscompares++; $display("FAIL single_c1_en got %b want 0010", en); end
        vectors++; if (en_b !== 4'b1101) begin miscompares++; $display("FAIL single_c1_en_b got %b want 1101", en_b); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL single_c1_ack got %b want 0000", ack); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_c1_busy got %b want 1", busy); end
        tick(); // cycle 2: SAMPLE
        vectors++; if (en !== 4'b0010) begin miscompares++; $display("FAIL single_c2_en got %b want 0010", en); end
        vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL single_c2_ack got %b want 0010", ack); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_c2_valid got %b want 0", out_valid); end
        req = 4'b0000;
        tick(); // cycle 3: TURN
        vectors++; if (en !== 4'b0000) begin miscompares++; $display("FAIL single_c3_en got %b want 0000", en); end
        vectors++; if (en_b !== 4'b1111) begin miscompares++; $display("FAIL single_c3_en_b got %b want 1111", en_b); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL single_c3_ack got %b want 0000", ack); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_c3_valid got %b want 1", out_valid); end
        vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL single_c3_data got %h want a5", out_data); end
        vectors++; if (out_src !== 2'd1) begin miscompares++; $display("FAIL single_c3_src got %0d want 1", out_src); end
        tick(); // cycle 4: IDLE
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_c4_busy got %b want 0", busy); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_en;
        int         t;
        int         ph;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) src_data[i] = 8'(i * 8'h11);
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            t  = (c - 1) / 4;
            ph = (c - 1) % 4;
            exp_en = (ph < 2) ? (4'b0001 << (t % 4)) : 4'b0000;
            vectors++; if (en !== exp_en) begin miscompares++; $display("FAIL rr_en cyc %0d got %b want %b", c, en, exp_en); end
            vectors++; if (en_b !== ~en) begin miscompares++; $display("FAIL rr_en_b cyc %0d got %b want %b", c, en_b, ~en); end
            if (ph == 1) begin
                vectors++; if (ack !== exp_en) begin miscompares++; $display("FAIL rr_ack cyc %0d got %b want %b", c, ack, exp_en); end
            end
            if (ph == 2) begin
                vectors++; if (out_valid !== 1'b1 || out_data !== 8'(t % 4 * 8'h11) || out_src !== 2'(t % 4)) begin
                    miscompares++; $display("FAIL rr_word cyc %0d got v%b %h/%0d want v1 %h/%0d", c, out_valid, out_data, out_src, 8'(t % 4 * 8'h11), t % 4);
                end
            end
        end
        req = 4'b0000;
        repeat (4) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int acks;
        out_ready = 1'b0;
        src_data[0] = 8'h40;
        req = 4'b0001;
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ack != 0) begin acks++; tick(); src_data[0] = src_data[0] + 8'd1; end
        end
        vectors++; if (acks !== 4) begin miscompares++; $display("FAIL bp_fill_acks got %0d want 4", acks); end
        vectors++; if (en !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_stall got en %b busy %b want 0000 0", en, busy); end
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin miscompares++; $display("FAIL bp_head got v%b %h want v1 40", out_valid, out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        vectors++; if (out_data !== 8'h41) begin miscompares++; $display("FAIL bp_pop_head got %h want 41", out_data); end
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ack != 0) begin acks++; tick(); src_data[0] = src_data[0] + 8'd1; end
        end
        vectors++; if (acks !== 1) begin miscompares++; $display("FAIL bp_refill_acks got %0d want 1", acks); end
        req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'(8'h41 + k) || out_src !== 2'd0) begin
                miscompares++; $display("FAIL bp_drain%0d got v%b %h/%0d want v1 %h/0", k, out_valid, out_data, out_src, 8'(8'h41 + k));
            end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_simul_push_pop();
        int got;
        out_ready = 1'b0;
        src_data[2] = 8'h21;
        req = 4'b0100;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            tick();
            if (ack != 0) begin
                got++;
                // Third capture: pop the head in the same cycle as the push.
                if (got == 3) begin out_ready = 1'b1; req = 4'b0000; end
                tick();
                out_ready = 1'b0;
                src_data[2] = src_data[2] + 8'd1;
            end
        end
        req = 4'b0000;
        vectors++; if (got !== 3) begin miscompares++; $display("FAIL pp_acks got %0d want 3", got); end
        tick(); tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_src !== 2'd2) begin
            miscompares++; $display("FAIL pp_head0 got v%b %h/%0d want v1 22/2", out_valid, out_data, out_src);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h23) begin
            miscompares++; $display("FAIL pp_head1 got v%b %h want v1 23", out_valid, out_data);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_transfer();
        int waited;
        src_data[2] = 8'h77;
        req = 4'b0100;
        waited = 0;
        while (en == 4'b0000 && waited < 10) begin tick(); waited++; end
        vectors++; if (en !== 4'b0100) begin miscompares++; $display("FAIL mid_drive_en got %b want 0100", en); end
        reset = 1'b1;
        #1;
        vectors++; if (en !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_en got %b want 0000", en); end
        vectors++; if (en_b !== 4'b1111) begin miscompares++; $display("FAIL mid_rst_en_b got %b want 1111", en_b); end
        vectors++; if (ack !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_rst_outs got ack %b v%b busy %b want 0000 0 0", ack, out_valid, busy);
        end
        tick();
        vectors++; if (ack !== 4'b0000 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_hold got ack %b v%b want 0000 0", ack, out_valid); end
        reset = 1'b0;
        req = 4'b1111;
        waited = 0;
        while (ack == 4'b0000 && waited < 10) begin tick(); waited++; end
        vectors++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL mid_fresh_grant got %b want 0001", ack); end
        req = 4'b0000;
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_contention();
        for (int i = 0; i < N; i++) src_data[i] = 8'(i * 8'h11);
        for (int p = 0; p < 200; p++) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            for (int c = 0; c < 3; c++) begin
                tick();
                vectors++; if ($countones(en) > 1 || en_b !== ~en) begin
                    miscompares++; $display("FAIL cont_en pat %0d got en %b en_b %b", p, en, en_b);
                end
                if (ack != 0) begin
                    vectors++; if (n_drv != 1 || en !== ack) begin
                        miscompares++; $display("FAIL cont_sample pat %0d got drivers %0d en %b ack %b want 1 driver", p, n_drv, en, ack);
                    end
                end
                if (out_valid) begin
                    vectors++; if (out_data !== src_data[out_src]) begin
                        miscompares++; $display("FAIL cont_word pat %0d got %h want %h (src %0d)", p, out_data, src_data[out_src], out_src);
                    end
                end
            end
        end
        req = 4'b0000;
        out_ready = 1'b1;
        repeat (10) tick();
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL cont_drain got v%b busy %b want 0 0", out_valid, busy); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) src_data[i] = '0;
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid_transfer();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
